mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle multiply/divide sequencer owning the HI/LO registers
//
// Purpose:
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the EX stage. The
//   arithmetic result is computed and captured in a pending register at
//   accept time. The sequencer then holds busy for a fixed number of
//   cycles and commits the pending value to HI/LO when the count runs out.
//   MTHI/MTLO write HI/LO directly in a single cycle.
//
// Ports:
//   clk         single clock, all state on rising edge
//   reset       asynchronous active-high reset
//   start       EX-stage issue strobe for the op on op
//   op          0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 ignored
//   rs_val      forwarded rs operand (dividend / multiplicand / MT source)
//   rt_val      forwarded rt operand (divisor / multiplier)
//   flush       cancels the op issuing in the same cycle
//   id_uses_md  ID-stage instruction touches the multiply/divide unit
//   busy        registered, high while a multiply/divide is in flight
//   hi, lo      architectural HI/LO registers
//   md_stall    combinational stall request to the hazard unit

module mdu_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        id_uses_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // The counter is loaded with latency-1 so that busy is high for exactly
    // the latency: the final edge with cnt==0 is the commit edge.
    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;   // low for divide-by-zero: HI/LO stay untouched

    logic        accept;

    // ------------------------------------------------------------------
    // Multiplier: 64x64 on extended operands, truncated to 64 bits. For the
    // signed case the sign-extended product modulo 2^64 is the exact
    // two's-complement product.
    // ------------------------------------------------------------------
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;

    always_comb begin
        mul_signed = (op == OP_MULT);
        mul_a      = mul_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        mul_b      = mul_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        mul_prod   = mul_a * mul_b;
    end

    // ------------------------------------------------------------------
    // Divider: magnitude divide then sign fix-up. Quotient truncates toward
    // zero, remainder follows the dividend sign. A zero divisor is replaced
    // by one so the arithmetic stays defined; the result is discarded.
    // ------------------------------------------------------------------
    logic        div_signed;
    logic        div_zero;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;

    always_comb begin
        div_signed = (op == OP_DIV);
        div_zero   = (rt_val == 32'd0);
        a_neg      = div_signed & rs_val[31];
        b_neg      = div_signed & rt_val[31];
        a_mag      = a_neg ? (32'd0 - rs_val) : rs_val;
        if (div_zero) begin
            b_mag = 32'd1;
        end else begin
            b_mag = b_neg ? (32'd0 - rt_val) : rt_val;
        end
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        div_q = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        div_r = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // ------------------------------------------------------------------
    // Accept / stall
    // ------------------------------------------------------------------
    assign accept = start & ~flush & (state == S_IDLE);

    // Stall on the issue cycle as well as in flight so the following
    // MD-using instruction never sees a stale HI/LO.
    assign md_stall = id_uses_md & (busy | (start & ~flush & (op <= OP_DIVU)));

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi <= mul_prod[63:32];
                                pend_lo <= mul_prod[31:0];
                                pend_wr <= 1'b1;
                                state   <= S_MUL;
                                cnt     <= MULT_CNT;
                                busy    <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (!div_zero) begin
                                    pend_hi <= div_r;
                                    pend_lo <= div_q;
                                end
                                pend_wr <= ~div_zero;
                                state   <= S_DIV;
                                cnt     <= DIV_CNT;
                                busy    <= 1'b1;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    // start here is a protocol violation and is ignored;
                    // flush never cancels an operation already in flight.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        pend_wr <= 1'b0;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer

module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        id_uses_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    mdu_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .flush      (flush),
        .id_uses_md (id_uses_md),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo),
        .md_stall   (md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1 while busy may be high; returns cycles busy was
    // observed high. An expired bound is reported as a failure.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Issue one op at posedge+1 and wait for it to finish.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int   n;
        int   ms;
        exp_t e;

        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        flush = 1'b0; id_uses_md = 1'b0;
        #2;
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_hi",    hi, 32'd0);
        chk("reset_lo",    lo, 32'd0);
        chk("reset_stall", {31'd0, md_stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        //            op     rs            rt            hi            lo            lat
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[5]  = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
        vecs[6]  = '{3'd4, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h0000000E, 0};
        vecs[7]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D, 0};
        vecs[8]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[10] = '{3'd6, 32'h11111111, 32'h22222222, 32'h40000000, 32'h00000000, 0};
        vecs[11] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};

        for (int i = 0; i < 12; i++) begin
            sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].lat});
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, n);
            e = sb.pop_front();
            chk($sformatf("vec%0d_lat", i), 32'(n), 32'(e.lat));
            chk($sformatf("vec%0d_hi", i), hi, e.hi);
            chk($sformatf("vec%0d_lo", i), lo, e.lo);
        end

        // md_stall on the issue cycle plus every busy cycle
        id_uses_md = 1'b1;
        op = 3'd0; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
        #1 chk("stall_issue", {31'd0, md_stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        ms = 0; n = 0;
        while (busy && n < 40) begin
            if (md_stall) ms++;
            n++;
            @(posedge clk); #1;
        end
        chk("stall_busy_cycles", 32'(ms), 32'd5);
        chk("stall_after", {31'd0, md_stall}, 32'd0);
        chk("mult5x6_lo", lo, 32'd30);
        id_uses_md = 1'b0;
        op = 3'd0; rs_val = 32'd7; rt_val = 32'd8; start = 1'b1;
        #1 chk("nostall_issue", {31'd0, md_stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        ms = 0; n = 0;
        while (busy && n < 40) begin
            if (md_stall) ms++;
            n++;
            @(posedge clk); #1;
        end
        chk("nostall_busy", 32'(ms), 32'd0);
        chk("mult7x8_lo", lo, 32'h38);

        // flushed DIV issue is dropped
        op = 3'd2; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'h38);
        repeat (3) @(posedge clk); #1;
        chk("flush_lo_later", lo, 32'h38);

        // flush mid-DIV does not cancel it: -100/7 -> q=-14, r=-2
        op = 3'd2; rs_val = 32'hFFFFFF9C; rt_val = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            flush = (n == 4);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        chk("middiv_flush_lat", 32'(n), 32'd10);
        chk("middiv_flush_hi", hi, 32'hFFFFFFFE);
        chk("middiv_flush_lo", lo, 32'hFFFFFFF2);

        // reset in busy cycle 3 of a MULT clears everything asynchronously
        op = 3'd0; rs_val = 32'h00010000; rt_val = 32'h00010000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        #1 reset = 1'b0;
        op = 3'd4; rs_val = 32'h12345678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mthi_after_reset_hi", hi, 32'h12345678);
        chk("mthi_after_reset_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(posedge clk); #1;
        chk("no_commit_hi", hi, 32'h12345678);
        chk("no_commit_lo", lo, 32'd0);
        chk("no_commit_busy", {31'd0, busy}, 32'd0);

        // back-to-back MTLO then MULT, with an illegal start while busy
        op = 3'd5; rs_val = 32'hA5A5A5A5; start = 1'b1;
        @(posedge clk); #1;
        chk("mtlo_lo", lo, 32'hA5A5A5A5);
        op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_lo_held", lo, 32'hA5A5A5A5);
        $display("NOTE protocol violation injected: start while busy (must be ignored)");
        op = 3'd4; rs_val = 32'hFFFF0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("viol_hi_unchanged", hi, 32'h12345678);
        chk("viol_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        chk("b2b_remaining_lat", 32'(n), 32'd4);
        chk("b2b_hi", hi, 32'd0);
        chk("b2b_lo", lo, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
